// File: rtl/slice_stream_responder_pkg.sv
// Shared constants, FSM state type and edge-detect helper for the
// slice stream responder and its slice RAM.
package slice_stream_responder_pkg;

  localparam int LINE_W  = 25;     // slice width (5x5 plane)
  localparam int DEPTH   = 64;     // slices per state
  localparam int ADDR_W  = 6;      // log2(DEPTH)
  localparam int TIMEOUT = 31000;  // watchdog limit, DONE_TIMEOUT_EN only

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RUN    = 2'd1,
    UNLOAD = 2'd2
  } state_t;

  // Rising edge: high now, low on the previous cycle.
  function automatic logic rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/slice_stream_responder_ram.sv
// DEPTH x LINE_W slice storage: one synchronous write port and one
// combinational read port.
module slice_ram
  import slice_stream_responder_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [LINE_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [DEPTH];

  // Write port.
  // NOTE: storage is deliberately not reset; validity is tracked outside the array.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/slice_stream_responder.sv
// Slice stream responder: host loads DEPTH slices, the encoder reads them by
// address and writes results back, and the results stream out over
// valid/ready. Optional watchdog: define DONE_TIMEOUT_EN to add the RUN
// cycle counter and the sticky err_timeout output.
module slice_stream_responder
  import slice_stream_responder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [LINE_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              start,
  input  logic              donee,
  input  logic [ADDR_W-1:0] cnt_value,
  output logic [LINE_W-1:0] line_in,
  input  logic              write_enable,
  input  logic [LINE_W-1:0] write_value,
  output logic              ul_valid,
  output logic [LINE_W-1:0] ul_data,
  output logic              ul_last,
  input  logic              ul_ready,
  output logic              busy,
`ifdef DONE_TIMEOUT_EN
  output logic              err_timeout,
`endif
  output logic              err_overflow,
  output logic              err_short
);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   ld_ptr;
  logic [ADDR_W:0]     wr_ptr;      // MSB set means all DEPTH slots captured
  logic [ADDR_W-1:0]   rd_ptr;
  logic [DEPTH-1:0]    valid_bits;
  logic                we_q, done_q;

  logic                in_run, load_beat, cap_edge, done_edge;
  logic                cap_take, cap_drop, finish_run, beat;
  logic [ADDR_W:0]     wr_inc;
  logic [ADDR_W-1:0]   ul_addr;
  logic [LINE_W-1:0]   out_rdata, ul_next;

  assign in_run    = (state == RUN);
  assign ld_ready  = (state == LOAD);
  assign start     = in_run;
  assign busy      = (state != LOAD);
  assign load_beat = ld_ready && ld_valid;
  assign cap_edge  = rise(write_enable, we_q);
  assign done_edge = rise(donee, done_q);
  assign cap_take  = in_run && cap_edge && !wr_ptr[ADDR_W];
  assign cap_drop  = in_run && cap_edge &&  wr_ptr[ADDR_W];
  assign wr_inc    = wr_ptr + {{ADDR_W{1'b0}}, cap_take};
  assign beat      = (state == UNLOAD) && ul_valid && ul_ready;

`ifdef DONE_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_hit;

  assign tmo_hit    = in_run && !done_edge && (tmo_cnt == 16'(TIMEOUT - 1));
  assign finish_run = in_run && (done_edge || tmo_hit);

  // Watchdog counts RUN cycles and restarts from zero on every RUN entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      tmo_cnt <= in_run ? tmo_cnt + 16'd1 : '0;
      if (tmo_hit) err_timeout <= 1'b1;
    end
  end
`else
  assign finish_run = in_run && done_edge;
`endif

  // Result slot to present next: slot 0 when leaving RUN, else the one after rd_ptr.
  assign ul_addr = in_run ? '0 : rd_ptr + ADDR_W'(1);
  // A capture into slot 0 on the same edge as done must bypass the array.
  assign ul_next = (cap_take && (wr_ptr == '0)) ? write_value
                 : (valid_bits[ul_addr] ? out_rdata : '0);

  slice_ram in_mem (
    .clk   (clk),
    .we    (load_beat),
    .waddr (ld_ptr),
    .wdata (ld_data),
    .raddr (cnt_value),
    .rdata (line_in)
  );

  slice_ram out_mem (
    .clk   (clk),
    .we    (cap_take),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (write_value),
    .raddr (ul_addr),
    .rdata (out_rdata)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= state_nxt;
  end

  // Next-state decode.
  // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (load_beat && (ld_ptr == ADDR_W'(DEPTH - 1))) state_nxt = RUN;
      RUN:     if (finish_run)         state_nxt = UNLOAD;
      UNLOAD:  if (beat && ul_last)    state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Pointers, capture bookkeeping, registered unload outputs and sticky errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_ptr       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      valid_bits   <= '0;
      we_q         <= 1'b0;
      done_q       <= 1'b0;
      ul_valid     <= 1'b0;
      ul_data      <= '0;
      ul_last      <= 1'b0;
      err_overflow <= 1'b0;
      err_short    <= 1'b0;
    end else begin
      we_q   <= write_enable;
      done_q <= donee;
      if (load_beat) ld_ptr <= ld_ptr + ADDR_W'(1);
      if (cap_take) begin
        wr_ptr                          <= wr_inc;
        valid_bits[wr_ptr[ADDR_W-1:0]] <= 1'b1;
      end
      if (cap_drop) err_overflow <= 1'b1;
      if (finish_run) begin
        ul_valid <= 1'b1;
        ul_data  <= ul_next;
        ul_last  <= (DEPTH == 1);
        rd_ptr   <= '0;
        if (!wr_inc[ADDR_W]) err_short <= 1'b1;
      end
      if (beat) begin
        if (ul_last) begin
          ul_valid   <= 1'b0;
          ul_data    <= '0;
          ul_last    <= 1'b0;
          wr_ptr     <= '0;
          rd_ptr     <= '0;
          valid_bits <= '0;
          we_q       <= 1'b0;
          done_q     <= 1'b0;
        end else begin
          rd_ptr  <= ul_addr;
          ul_data <= ul_next;
          ul_last <= (ul_addr == ADDR_W'(DEPTH - 1));
        end
      end
    end
  end

endmodule

// File: tb/tb_slice_stream_responder.sv
// Directed bench for slice_stream_responder: a small encoder model drives the
// slice interface, and a compare process checks every presented unload beat
// against the expected result array built from the loaded slices.
module tb_slice_stream_responder;
  import slice_stream_responder_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              ld_valid, ld_ready, start, donee;
  logic [LINE_W-1:0] ld_data, line_in, write_value, ul_data;
  logic [ADDR_W-1:0] cnt_value;
  logic              write_enable, ul_valid, ul_last, ul_ready, busy;
  logic              err_overflow, err_short;
`ifdef DONE_TIMEOUT_EN
  logic              err_timeout;
`endif

  int checks = 0;
  int errors = 0;
  int ul_k   = 0;                    // accepted unload beats in this run
  logic [LINE_W-1:0] in_slice [DEPTH];
  logic [LINE_W-1:0] exp_data [DEPTH];

  always #5 clk = ~clk;

  slice_stream_responder dut (
    .clk          (clk),
    .rst          (rst),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_ready     (ld_ready),
    .start        (start),
    .donee        (donee),
    .cnt_value    (cnt_value),
    .line_in      (line_in),
    .write_enable (write_enable),
    .write_value  (write_value),
    .ul_valid     (ul_valid),
    .ul_data      (ul_data),
    .ul_last      (ul_last),
    .ul_ready     (ul_ready),
    .busy         (busy),
`ifdef DONE_TIMEOUT_EN
    .err_timeout  (err_timeout),
`endif
    .err_overflow (err_overflow),
    .err_short    (err_short)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every presented result beat against the model; count accepted beats.
  always @(negedge clk) begin
    if (ul_valid === 1'b1) begin
      if (ul_k >= DEPTH) begin
        check("extra_beat", 32'(ul_k), 32'(DEPTH - 1));
      end else begin
        check("ul_data", 32'(ul_data), 32'(exp_data[ul_k]));
        check("ul_last", 32'(ul_last), 32'(ul_k == DEPTH - 1));
        if (ul_ready) ul_k++;
      end
    end
  end

  // Expected results: encoder returns ~slice for the first n writes, rest read 0.
  task automatic set_expected(input int n);
    for (int k = 0; k < DEPTH; k++)
      exp_data[k] = (k < n) ? ~in_slice[k] : '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic load_all();
    check("ld_ready_before_load", 32'(ld_ready), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1'b1;
      ld_data  = in_slice[i];
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
    check("ld_ready_in_run", 32'(ld_ready), 32'd0);
    check("start_in_run", 32'(start), 32'd1);
    check("busy_in_run", 32'(busy), 32'd1);
  endtask

  // Encoder model: n write edges, the first strobe held high for 'hold' cycles.
  task automatic encode(input int n, input int hold);
    for (int k = 0; k < n; k++) begin
      cnt_value = ADDR_W'(k % DEPTH);
      #1;
      if (k < DEPTH) check("line_in", 32'(line_in), 32'(in_slice[k]));
      write_value  = ~line_in;
      write_enable = 1'b1;
      repeat ((k == 0) ? hold : 1) @(posedge clk);
      #1;
      write_enable = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic raise_done();
    ul_ready = 1'b0;
    donee    = 1'b1;
    @(posedge clk); #1;
    check("ul_valid_latency", 32'(ul_valid), 32'd1);
    check("start_after_done", 32'(start), 32'd0);
    check("busy_unload", 32'(busy), 32'd1);
    donee = 1'b0;
  endtask

  // Drain results; optional stall at one beat, optional reset at one beat.
  task automatic unload(input int stall_at, input int stall_len, input int rst_at);
    int cyc   = 0;
    int stall = 0;
    while (ul_k < DEPTH && cyc < 500) begin
      if (ul_k == rst_at) begin
        rst = 1'b0;
        #1;
        check("rst_ul_valid", 32'(ul_valid), 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd1);
        check("rst_start", 32'(start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        return;
      end
      ul_ready = !(ul_k == stall_at && stall < stall_len);
      if (!ul_ready) stall++;
      @(posedge clk); #1;
      cyc++;
    end
    ul_ready = 1'b0;
    check("unload_beats", 32'(ul_k), 32'(DEPTH));
    check("back_to_load", 32'(ld_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ul_valid", 32'(ul_valid), 32'd0);
  endtask

  task automatic full_run(input int n, input int hold, input int stall_at,
                          input logic exp_ov, input logic exp_short);
    ul_k = 0;
    load_all();
    encode(n, hold);
    set_expected(n);
    raise_done();
    unload(stall_at, 5, -1);
    check("err_overflow", 32'(err_overflow), 32'(exp_ov));
    check("err_short", 32'(err_short), 32'(exp_short));
  endtask

  initial begin
    rst = 1'b0; ld_valid = 1'b0; ld_data = '0; donee = 1'b0;
    cnt_value = '0; write_enable = 1'b0; write_value = '0; ul_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) in_slice[i] = LINE_W'(i * 3);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    check("rst_start", 32'(start), 32'd0);
    check("rst_ul_valid", 32'(ul_valid), 32'd0);
    check("rst_ul_last", 32'(ul_last), 32'd0);
    check("rst_ul_data", 32'(ul_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_overflow", 32'(err_overflow), 32'd0);
    check("rst_err_short", 32'(err_short), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Pin the model with hand-computed values.
    set_expected(64);
    check("model_exp1", 32'(exp_data[1]), 32'h1FFFFFC);
    check("model_exp63", 32'(exp_data[63]), 32'h1FFFF42);
    set_expected(40);
    check("model_exp40_short", 32'(exp_data[40]), 32'h0);

    // Clean run, stalled for 5 cycles at beat 10; first beat pinned literally.
    ul_k = 0;
    load_all();
    encode(64, 1);
    set_expected(64);
    raise_done();
    check("first_beat_literal", 32'(ul_data), 32'h1FFFFFF);
    unload(10, 5, -1);
    check("clean_err_overflow", 32'(err_overflow), 32'd0);
    check("clean_err_short", 32'(err_short), 32'd0);

    // First strobe held high 3 cycles: must capture only once.
    full_run(64, 3, -1, 1'b0, 1'b0);

    // 65 write edges: last one dropped, overflow flagged.
    full_run(65, 1, -1, 1'b1, 1'b0);
    do_reset();

    // 40 writes then done: short flagged, beats 40..63 read zero.
    full_run(40, 1, 7, 1'b0, 1'b1);
    do_reset();

    // Reset during unload at beat 20, then a clean run.
    ul_k = 0;
    load_all();
    encode(64, 1);
    set_expected(64);
    raise_done();
    unload(-1, 0, 20);
    check("post_rst_err_overflow", 32'(err_overflow), 32'd0);
    full_run(64, 1, -1, 1'b0, 1'b0);

`ifdef DONE_TIMEOUT_EN
    begin
      int cyc = 0;
      do_reset();
      ul_k = 0;
      load_all();
      while (ul_valid !== 1'b1 && cyc < 32000) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("timeout_cycles", 32'(cyc), 32'(TIMEOUT));
      check("err_timeout", 32'(err_timeout), 32'd1);
      check("timeout_err_short", 32'(err_short), 32'd1);
      set_expected(0);
      unload(-1, 0, -1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
